// File: rtl/ghost_status_scheduler.sv
// Round-robin arbiter sharing one 16-bit status PIO word among up to four ghost AI units.
// A posted word raises irq and is held until a software ack edge or the ack timeout.
module ghost_status_scheduler #(
  parameter int NUM_GHOSTS  = 4,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_GHOSTS-1:0]    req,
  input  logic [NUM_GHOSTS*12-1:0] data,
  input  logic                     sw_ack,
  output logic [NUM_GHOSTS-1:0]    grant,
  output logic [15:0]              status_out,
  output logic                     irq
);

  typedef enum logic {IDLE, WAIT_ACK} state_t;

  localparam int              CNT_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  localparam logic [1:0]      PTR_INIT = 2'(NUM_GHOSTS - 1);
  localparam logic [2:0]      N3       = 3'(NUM_GHOSTS);

  state_t                  state_q;
  logic [1:0]              ptr_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    sw_ack_q;
  logic [NUM_GHOSTS-1:0]   grant_q;
  logic [15:0]             status_q;

  logic [3:0]              req_ext;
  logic [3:0][11:0]        data_ext;
  logic [1:0]              win_d;
  logic                    win_found_d;
  logic [2:0]              idx_d;
  logic                    ack_rise;
  logic                    expired;

  // Pad requests and payloads to four slots so the search logic is width-independent.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
      if (gi < NUM_GHOSTS) begin : g_used
        assign req_ext[gi]  = req[gi];
        assign data_ext[gi] = data[12*gi +: 12];
      end else begin : g_unused
        assign req_ext[gi]  = 1'b0;
        assign data_ext[gi] = 12'h000;
      end
    end
  endgenerate

  // Search ptr+1, ptr+2, ... modulo NUM_GHOSTS; the first set request wins.
  always_comb begin
    win_d       = ptr_q;
    win_found_d = 1'b0;
    idx_d       = 3'd0;
    for (int k = 1; k <= NUM_GHOSTS; k++) begin
      idx_d = {1'b0, ptr_q} + 3'(k);
      if (idx_d >= N3) begin
        idx_d = idx_d - N3;
      end
      if (!win_found_d && req_ext[idx_d[1:0]]) begin
        win_found_d = 1'b1;
        win_d       = idx_d[1:0];
      end
    end
  end

  assign ack_rise = sw_ack & ~sw_ack_q;
  assign expired  = (ACK_TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ptr_q    <= PTR_INIT;
      cnt_q    <= '0;
      sw_ack_q <= 1'b0;
      grant_q  <= '0;
      status_q <= 16'h0000;
    end else begin
      sw_ack_q <= sw_ack;
      grant_q  <= '0;
      case (state_q)
        IDLE: begin
          if (win_found_d) begin
            grant_q  <= NUM_GHOSTS'(4'b0001 << win_d);
            ptr_q    <= win_d;
            status_q <= {2'b10, win_d, data_ext[win_d]};
            cnt_q    <= '0;
            state_q  <= WAIT_ACK;
          end else begin
            status_q[15] <= 1'b0;
          end
        end
        WAIT_ACK: begin
          // An ack landing on the expiry cycle takes precedence, so timeout stays clear.
          if (ack_rise) begin
            status_q[15:14] <= 2'b00;
            cnt_q           <= '0;
            state_q         <= IDLE;
          end else if (expired) begin
            status_q[15:14] <= 2'b01;
            cnt_q           <= '0;
            state_q         <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant      = grant_q;
  assign status_out = status_q;
  assign irq        = status_q[15];

endmodule

// File: tb/tb_ghost_status_scheduler.sv
// Bench for ghost_status_scheduler: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a transaction-level model.
module tb_ghost_status_scheduler;

  localparam int N  = 4;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req;
  logic [N*12-1:0] data;
  logic            sw_ack;
  logic [N-1:0]    grant;
  logic [15:0]     status_out;
  logic            irq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ghost_status_scheduler #(.NUM_GHOSTS(N), .ACK_TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .data       (data),
    .sw_ack     (sw_ack),
    .grant      (grant),
    .status_out (status_out),
    .irq        (irq)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a posted word is "held" for up to TO cycles; the rr search starts after the last winner.
  bit          m_valid = 1'b0;
  bit          m_busy;
  bit          m_prev_ack;
  bit          m_rise;
  logic [15:0] m_word;
  logic [3:0]  m_grant = 4'b0000;
  int          m_last;
  int          m_waited;
  int          m_win;

  always @(posedge clk) begin
    m_rise     = sw_ack && !m_prev_ack;
    m_prev_ack = sw_ack;
    if (!reset_n) begin
      m_valid    = 1'b1;
      m_busy     = 1'b0;
      m_prev_ack = 1'b0;
      m_word     = 16'h0000;
      m_grant    = 4'b0000;
      m_last     = N - 1;
      m_waited   = 0;
    end else if (m_valid) begin
      m_grant = 4'b0000;
      if (!m_busy) begin
        m_win = -1;
        for (int d = 1; d <= N; d++) begin
          if (m_win < 0 && req[(m_last + d) % N]) m_win = (m_last + d) % N;
        end
        if (m_win >= 0) begin
          m_grant  = 4'(1 << m_win);
          m_last   = m_win;
          m_word   = {2'b10, 2'(m_win), data[12*m_win +: 12]};
          m_busy   = 1'b1;
          m_waited = 0;
        end else begin
          m_word[15] = 1'b0;
        end
      end else begin
        m_waited++;
        if (m_rise) begin
          m_word[15:14] = 2'b00;
          m_busy        = 1'b0;
        end else if (TO != 0 && m_waited == TO) begin
          m_word[15:14] = 2'b01;
          m_busy        = 1'b0;
        end
      end
    end
    #2;
    if (m_valid) begin
      check("model_grant", 16'(grant), 16'(m_grant));
      check("model_status", status_out, m_word);
      check("model_irq", 16'(irq), 16'(m_word[15]));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_grant(input string name);
    int i;
    i = 0;
    while (grant == '0 && i < 20) begin
      @(negedge clk);
      i++;
    end
    if (grant == '0) begin
      total++;
      bad++;
      $display("FAIL %s: no grant within 20 cycles", name);
    end
  endtask

  initial begin
    req     = '0;
    data    = '0;
    sw_ack  = 1'b0;
    reset_n = 1'b0;
    step(3);
    check("reset_status", status_out, 16'h0000);
    check("reset_irq", 16'(irq), 16'h0000);
    check("reset_grant", 16'(grant), 16'h0000);

    // Single post from ghost 0
    reset_n = 1'b1;
    req = 4'b0001;
    data[11:0] = 12'hABC;
    step(1);
    check("t1_grant", 16'(grant), 16'h0001);
    check("t1_status", status_out, 16'h8ABC);
    check("t1_irq", 16'(irq), 16'h0001);
    req = '0;
    step(1);
    check("t1_pulse", 16'(grant), 16'h0000);

    // Ack edge, then level held high
    sw_ack = 1'b1;
    step(1);
    check("t2_status", status_out, 16'h0ABC);
    check("t2_irq", 16'(irq), 16'h0000);
    step(3);
    check("t2_hold", status_out, 16'h0ABC);
    sw_ack = 1'b0;
    step(1);

    // Round robin with all four requesting
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    for (int i = 0; i < N; i++) data[12*i +: 12] = 12'(12'h5A0 + i);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant("t3_wait");
      check("t3_grant", 16'(grant), 16'(1 << (k % 4)));
      check("t3_id", 16'(status_out[13:12]), 16'(k % 4));
      check("t3_payload", 16'(status_out[11:0]), 16'(12'h5A0 + (k % 4)));
      if (k == 4) req = '0;
      sw_ack = 1'b1;
      step(1);
      sw_ack = 1'b0;
      step(1);
    end

    // Timeout expiry, then new post clears the timeout bit
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    req = 4'b0001;
    data[11:0] = 12'h123;
    wait_grant("t4_wait");
    req = '0;
    step(7);
    check("t4_before", 16'(status_out[15:14]), 16'(2'b10));
    step(1);
    check("t4_timeout", 16'(status_out[15:14]), 16'(2'b01));
    check("t4_irq", 16'(irq), 16'h0000);
    req = 4'b0010;
    data[23:12] = 12'h456;
    step(1);
    check("t4_repost", status_out, 16'h9456);
    check("t4_grant", 16'(grant), 16'h0002);
    req = '0;

    // Ack on the expiry cycle wins; a req raised with the ack is granted two cycles later
    step(7);
    sw_ack = 1'b1;
    req = 4'b0100;
    data[35:24] = 12'h789;
    step(1);
    check("t5_ack_wins", status_out, 16'h1456);
    check("t5_no_grant", 16'(grant), 16'h0000);
    step(1);
    check("t5_grant", 16'(grant), 16'h0004);
    check("t5_status", status_out, 16'hA789);

    // Reset during WAIT_ACK
    req = 4'b1110;
    reset_n = 1'b0;
    step(1);
    check("t6_status", status_out, 16'h0000);
    check("t6_irq", 16'(irq), 16'h0000);
    reset_n = 1'b1;
    step(1);
    check("t6_grant", 16'(grant), 16'h0002);
    check("t6_post", status_out, 16'h9456);
    sw_ack = 1'b0;
    req = '0;
    step(2);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      req = req & ~m_grant;
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          data[12*i +: 12] = 12'($urandom);
          req[i] = 1'b1;
        end
      end
      if ($urandom_range(0, 4) == 0) sw_ack = ~sw_ack;
      reset_n = ($urandom_range(0, 399) != 0);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
